// File: rtl/sccpu_trace_pkg.sv
// Shared types and record layout for the single-cycle CPU trace buffer.
// The ARMED state exists only when TRACE_TRIGGER_EN is defined.
package sccpu_trace_pkg;

  localparam int TRACE_REC_W   = 96;
  localparam int REC_PC_LSB    = 64;
  localparam int REC_INST_LSB  = 32;
  localparam int REC_ALU_LSB   = 0;
  localparam int REC_FIELD_W   = 32;

`ifdef TRACE_TRIGGER_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } trace_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } trace_state_e;
`endif

  function automatic logic [TRACE_REC_W-1:0] pack_record(
    input logic [REC_FIELD_W-1:0] pc,
    input logic [REC_FIELD_W-1:0] inst,
    input logic [REC_FIELD_W-1:0] alu
  );
    logic [TRACE_REC_W-1:0] rec;
    rec = '0;
    rec[REC_PC_LSB   +: REC_FIELD_W] = pc;
    rec[REC_INST_LSB +: REC_FIELD_W] = inst;
    rec[REC_ALU_LSB  +: REC_FIELD_W] = alu;
    return rec;
  endfunction

endpackage

// File: rtl/sccpu_trace_buffer_if.sv
// Core-commit, control and read-port bundle of the trace buffer.
// slave = the trace buffer, master = whatever drives the core side and consumes records.
interface sccpu_trace_buffer_if #(
  parameter int ADDR_W = 4
);
  import sccpu_trace_pkg::*;

  logic                   Clear;
  logic                   Arm;
  logic                   Stop;
  logic                   Retire;
  logic [31:0]            PC;
  logic [31:0]            Inst;
  logic [31:0]            Alu_Result;
  logic [31:0]            Trig_PC;
  logic                   Rd_Valid;
  logic                   Rd_Ready;
  logic [TRACE_REC_W-1:0] Rd_Data;
  logic [ADDR_W:0]        Count;
  logic                   Busy;
  logic                   Done;

  modport slave (
    input  Clear, Arm, Stop, Retire, PC, Inst, Alu_Result, Trig_PC, Rd_Ready,
    output Rd_Valid, Rd_Data, Count, Busy, Done
  );

  modport master (
    output Clear, Arm, Stop, Retire, PC, Inst, Alu_Result, Trig_PC, Rd_Ready,
    input  Rd_Valid, Rd_Data, Count, Busy, Done
  );

endinterface

// File: rtl/sccpu_trace_ram.sv
// Trace record storage: one synchronous write port, one asynchronous read port, no reset.
module sccpu_trace_ram
  import sccpu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [TRACE_REC_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [TRACE_REC_W-1:0] rdata
);

  logic [TRACE_REC_W-1:0] mem_r [DEPTH];

  // Record write on capture
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sccpu_trace_buffer.sv
// Trace capture of committed {PC, Inst, Alu_Result} records with valid/ready drain.
// Define TRACE_TRIGGER_EN to add the ARMED state that waits for PC == Trig_PC.
module sccpu_trace_buffer
  import sccpu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  sccpu_trace_buffer_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_C    = DEPTH_C - (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ONE_C = (ADDR_W+1)'(1);

  trace_state_e           state_r, state_s;
  logic [ADDR_W-1:0]      wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0]      rd_ptr_r, rd_ptr_s;
  logic [ADDR_W:0]        count_r, count_s;
  logic                   wr_en_s;
  logic                   pop_s;
  logic                   rd_valid_s;
  logic [TRACE_REC_W-1:0] ram_rdata_s;
  logic [TRACE_REC_W-1:0] wr_rec_s;

`ifdef TRACE_TRIGGER_EN
  logic trig_hit_s;
  assign trig_hit_s = bus.Retire && (bus.PC == bus.Trig_PC);
`else
  logic unused_trig_s;
  assign unused_trig_s = ^bus.Trig_PC;
`endif

  assign wr_rec_s   = pack_record(bus.PC, bus.Inst, bus.Alu_Result);
  assign rd_valid_s = (state_r == ST_DRAIN) && (count_r != '0);

  // Next-state, pointer and occupancy logic; Clear overrides everything
  always_comb begin
    state_s  = state_r;
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    wr_en_s  = 1'b0;
    pop_s    = 1'b0;
    if (bus.Clear) begin
      state_s  = ST_IDLE;
      wr_ptr_s = '0;
      rd_ptr_s = '0;
      count_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Arm) begin
`ifdef TRACE_TRIGGER_EN
            state_s = ST_ARMED;
`else
            state_s = ST_CAPTURE;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
`ifdef TRACE_TRIGGER_EN
        ST_ARMED: begin
          // The triggering instruction is itself the first record
          if (trig_hit_s) begin
            wr_en_s = 1'b1;
            state_s = bus.Stop ? ST_DRAIN : ST_CAPTURE;
          end else if (bus.Stop) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ARMED;
          end
        end
`endif
        ST_CAPTURE: begin
          wr_en_s = bus.Retire && (count_r < DEPTH_C);
          if (bus.Stop) begin
            state_s = ((count_r == '0) && !wr_en_s) ? ST_IDLE : ST_DRAIN;
          end else if (wr_en_s && (count_r == LAST_C)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        ST_DRAIN: begin
          pop_s = rd_valid_s && bus.Rd_Ready;
          if ((count_r == '0) || (pop_s && (count_r == CNT_ONE_C))) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      if (wr_en_s) begin
        wr_ptr_s = wr_ptr_r + ADDR_W'(1);
        count_s  = count_r + CNT_ONE_C;
      end else if (pop_s) begin
        rd_ptr_s = rd_ptr_r + ADDR_W'(1);
        count_s  = count_r - CNT_ONE_C;
      end else begin
        count_s  = count_r;
      end
    end
  end

  // State, pointer and occupancy registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      state_r  <= state_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
    end
  end

  sccpu_trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (Clock),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (wr_rec_s),
    .raddr (rd_ptr_r),
    .rdata (ram_rdata_s)
  );

  assign bus.Rd_Valid = rd_valid_s;
  assign bus.Rd_Data  = rd_valid_s ? ram_rdata_s : '0;
  assign bus.Count    = count_r;
`ifdef TRACE_TRIGGER_EN
  assign bus.Busy     = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
`else
  assign bus.Busy     = (state_r == ST_CAPTURE);
`endif
  assign bus.Done     = (state_r == ST_DRAIN);

endmodule

// File: tb/tb_sccpu_trace_buffer.sv
// Scoreboard bench for sccpu_trace_buffer; the trigger scenario runs only with TRACE_TRIGGER_EN.
module tb_sccpu_trace_buffer;

  logic Clock;
  logic Reset;
  int   checks;
  int   failures;
  logic [95:0] exp_q[$];
  logic [95:0] exp_rec;

  sccpu_trace_buffer_if #(.ADDR_W(4)) bus ();

  sccpu_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [95:0] mk_rec(input logic [31:0] pc);
    return {pc, pc ^ 32'hDEAD_0000, pc + 32'h0000_1000};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_retire(input logic ret, input logic [31:0] pc, input logic stop);
    bus.Retire     = ret;
    bus.PC         = pc;
    bus.Inst       = pc ^ 32'hDEAD_0000;
    bus.Alu_Result = pc + 32'h0000_1000;
    bus.Stop       = stop;
    tick();
    bus.Retire = 1'b0;
    bus.Stop   = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    checks += 5;
    if (bus.Count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
    if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.Rd_Valid); end
    if (bus.Rd_Data !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.Rd_Data); end
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_full_capture();
    int cyc;
    pulse_arm();
    checks++;
    if (bus.Busy !== 1'b1) begin failures++; $display("FAIL full_busy_arm got=%b exp=1", bus.Busy); end
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(mk_rec(32'(i * 4)));
      drive_retire(1'b1, 32'(i * 4), 1'b0);
      checks += 2;
      if (bus.Done !== (i >= 15)) begin failures++; $display("FAIL full_done i=%0d got=%b exp=%b", i, bus.Done, (i >= 15)); end
      if (bus.Count !== ((i < 16) ? 5'(i + 1) : 5'd16)) begin
        failures++; $display("FAIL full_count i=%0d got=%0d", i, bus.Count);
      end
    end
    bus.Rd_Ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      checks++;
      if (bus.Rd_Valid !== 1'b1) begin
        failures++; $display("FAIL full_drain_valid cyc=%0d got=%b exp=1", cyc, bus.Rd_Valid);
      end else begin
        exp_rec = exp_q.pop_front();
        checks++;
        if (bus.Rd_Data !== exp_rec) begin failures++; $display("FAIL full_drain_data got=%h exp=%h", bus.Rd_Data, exp_rec); end
      end
      tick();
      cyc++;
    end
    bus.Rd_Ready = 1'b0;
    checks += 4;
    if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain_timeout left=%0d exp=0", exp_q.size()); exp_q.delete(); end
    if (cyc != 16) begin failures++; $display("FAIL full_drain_cycles got=%0d exp=16", cyc); end
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL full_idle done=%b busy=%b exp=0/0", bus.Done, bus.Busy); end
    if (bus.Rd_Valid !== 1'b0 || bus.Rd_Data !== 96'd0) begin failures++; $display("FAIL full_after_valid got=%b data=%h exp=0", bus.Rd_Valid, bus.Rd_Data); end
  endtask

  task automatic test_stop_toggle();
    int cyc;
    pulse_arm();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk_rec(32'h0000_0400 + 32'(i * 4)));
      drive_retire(1'b1, 32'h0000_0400 + 32'(i * 4), (i == 5));
    end
    checks += 2;
    if (bus.Count !== 5'd6) begin failures++; $display("FAIL stop_count got=%0d exp=6", bus.Count); end
    if (bus.Done !== 1'b1) begin failures++; $display("FAIL stop_done got=%b exp=1", bus.Done); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      bus.Rd_Ready = (cyc % 2 == 0);
      #1;
      checks += 2;
      if (bus.Rd_Valid !== 1'b1) begin failures++; $display("FAIL stop_valid cyc=%0d got=%b exp=1", cyc, bus.Rd_Valid); end
      if (bus.Rd_Data !== exp_q[0]) begin failures++; $display("FAIL stop_data cyc=%0d got=%h exp=%h", cyc, bus.Rd_Data, exp_q[0]); end
      if (bus.Rd_Ready) exp_rec = exp_q.pop_front();
      tick();
      cyc++;
    end
    bus.Rd_Ready = 1'b0;
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stop_timeout left=%0d exp=0", exp_q.size()); exp_q.delete(); end
    if (bus.Done !== 1'b0 || bus.Count !== 5'd0) begin failures++; $display("FAIL stop_idle done=%b count=%0d exp=0/0", bus.Done, bus.Count); end
  endtask

  task automatic test_stop_empty();
    pulse_arm();
    drive_retire(1'b0, 32'h0, 1'b1);
    checks += 2;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL empty_busy got=%b exp=0", bus.Busy); end
    if (bus.Done !== 1'b0) begin failures++; $display("FAIL empty_done got=%b exp=0", bus.Done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL empty_valid i=%0d got=%b exp=0", i, bus.Rd_Valid); end
      tick();
    end
  endtask

  task automatic test_clear();
    int cyc;
    pulse_arm();
    for (int i = 0; i < 9; i++) drive_retire(1'b1, 32'h0000_0100 + 32'(i * 4), 1'b0);
    drive_retire(1'b0, 32'h0, 1'b1);
    checks += 2;
    if (bus.Count !== 5'd9) begin failures++; $display("FAIL clear_pre_count got=%0d exp=9", bus.Count); end
    if (bus.Done !== 1'b1) begin failures++; $display("FAIL clear_pre_done got=%b exp=1", bus.Done); end
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    checks += 3;
    if (bus.Count !== 5'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", bus.Count); end
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL clear_state done=%b busy=%b exp=0/0", bus.Done, bus.Busy); end
    if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL clear_valid got=%b exp=0", bus.Rd_Valid); end
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_rec(32'h0000_0200 + 32'(i * 4)));
      drive_retire(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0);
    end
    drive_retire(1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.Count !== 5'd3) begin failures++; $display("FAIL clear_new_count got=%0d exp=3", bus.Count); end
    bus.Rd_Ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      exp_rec = exp_q.pop_front();
      checks++;
      if (bus.Rd_Valid !== 1'b1 || bus.Rd_Data !== exp_rec) begin
        failures++; $display("FAIL clear_new_data valid=%b got=%h exp=%h", bus.Rd_Valid, bus.Rd_Data, exp_rec);
      end
      tick();
      cyc++;
    end
    bus.Rd_Ready = 1'b0;
    checks++;
    if (bus.Done !== 1'b0 || bus.Count !== 5'd0) begin failures++; $display("FAIL clear_new_idle done=%b count=%0d exp=0/0", bus.Done, bus.Count); end
  endtask

  task automatic test_reset_mid();
    pulse_arm();
    for (int i = 0; i < 7; i++) drive_retire(1'b1, 32'h0000_0800 + 32'(i * 4), 1'b0);
    checks++;
    if (bus.Count !== 5'd7) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=7", bus.Count); end
    #2;
    Reset = 1'b1;
    #1;
    checks += 3;
    if (bus.Count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.Count); end
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.Busy); end
    if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.Rd_Valid); end
    tick();
    Reset = 1'b0;
    tick();
  endtask

`ifdef TRACE_TRIGGER_EN
  task automatic test_trigger();
    int cyc;
    bus.Trig_PC = 32'h0000_0010;
    pulse_arm();
    checks += 2;
    if (bus.Busy !== 1'b1) begin failures++; $display("FAIL trig_busy_arm got=%b exp=1", bus.Busy); end
    if (bus.Count !== 5'd0) begin failures++; $display("FAIL trig_count_arm got=%0d exp=0", bus.Count); end
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) exp_q.push_back(mk_rec(32'(i * 4)));
      drive_retire(1'b1, 32'(i * 4), 1'b0);
      checks += 2;
      if (bus.Busy !== 1'b1) begin failures++; $display("FAIL trig_busy i=%0d got=%b exp=1", i, bus.Busy); end
      if (bus.Count !== ((i < 4) ? 5'd0 : 5'(i - 3))) begin failures++; $display("FAIL trig_count i=%0d got=%0d", i, bus.Count); end
    end
    drive_retire(1'b0, 32'h0, 1'b1);
    bus.Rd_Ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      exp_rec = exp_q.pop_front();
      checks++;
      if (bus.Rd_Valid !== 1'b1 || bus.Rd_Data !== exp_rec) begin
        failures++; $display("FAIL trig_data valid=%b got=%h exp=%h", bus.Rd_Valid, bus.Rd_Data, exp_rec);
      end
      tick();
      cyc++;
    end
    bus.Rd_Ready = 1'b0;
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    Reset        = 1'b1;
    bus.Clear    = 1'b0;
    bus.Arm      = 1'b0;
    bus.Stop     = 1'b0;
    bus.Retire   = 1'b0;
    bus.PC       = 32'h0;
    bus.Inst     = 32'h0;
    bus.Alu_Result = 32'h0;
    bus.Trig_PC  = 32'hFFFF_FFFF;
    bus.Rd_Ready = 1'b0;
    test_reset();
    test_full_capture();
    test_stop_toggle();
    test_stop_empty();
    test_clear();
    test_reset_mid();
`ifdef TRACE_TRIGGER_EN
    test_trigger();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
